fmap_tx_scheduler: RTL
======================

# fmap_tx_scheduler

Frame-level scheduler that shares one byte-wide UART transmitter between `NCH` feature-map sources. It grants one requesting channel at a time, round-robin, and reads that channel's `ROWS`×`COLS` 8-bit map through a synchronous read port. It emits a framed packet to the UART byte transmitter: header, channel id, data bytes in row-major order, checksum. It sits between the convolution/feature-map buffers and the UART byte transmitter, replacing ad-hoc per-map transmit sequencing.

## Interface
Parameters:
- `ROWS`, 6, feature-map rows
- `COLS`, 6, feature-map columns
- `NCH`, 2, number of requesting channels (2..8)
- `GAP_CYCLES`, 50000, idle clocks between frames (≥1)
- `HDR0`, 8'hA5, first sync byte
- `HDR1`, 8'h5A, second sync byte

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `req`  in  NCH  level request per channel; sampled only in arbitration
- `grant`  out  NCH  one-hot owner of the current frame; all-zero when idle
- `rd_row`  out  $clog2(ROWS)  read row address to the granted buffer
- `rd_col`  out  $clog2(COLS)  read column address
- `rd_data`  in  NCH×8 (packed, channel i at [8i+7:8i])  buffer read data; valid 1 cycle after the address
- `tx_byte`  out  8  byte to the UART transmitter; held stable from `tx_start` until the next `tx_start`
- `tx_start`  out  1  one-cycle launch pulse
- `tx_busy`  in  1  UART busy; UART raises it the cycle after `tx_start`
- `frame_done`  out  NCH  one-cycle pulse on the finished channel's bit
- `busy`  out  1  high in every state except IDLE

## Operation
- Frame = `HDR0`, `HDR1`, channel id (zero-extended to 8 bits), `ROWS*COLS` data bytes (row-major, col fastest), checksum. Default frame is 40 bytes.
- Checksum = (channel id + Σ data bytes) mod 256. It is accumulated in an 8-bit register with wrap-around. Headers are excluded.
- FSM states: IDLE, ARB, SEND_HDR0, SEND_HDR1, SEND_ID, RD_ADDR, RD_CAP, SEND_DATA, SEND_CSUM, GAP.
  - IDLE→ARB when any `req` is set.
  - ARB selects the first set `req` searching from `last+1` upward, with modulo NCH wrap. It sets `grant`, records `last`, and clears the checksum.
  - Each SEND_* state waits for tx ready, then pulses `tx_start` with `tx_byte`.
  - Data loop: RD_ADDR drives row/col, RD_CAP registers `rd_data[grant]`, SEND_DATA launches the byte and adds it to the checksum.
  - Column increments first. At col = COLS-1 the column wraps to 0 and the row increments. After (ROWS-1, COLS-1) the FSM goes to SEND_CSUM.
  - SEND_CSUM launches the checksum byte, then the block waits for `tx_busy`=0. It then pulses `frame_done`, clears `grant`, and enters GAP.
  - GAP counts `GAP_CYCLES`, then goes to ARB if any `req` is set, otherwise to IDLE.
- Tx ready = `tx_busy`=0, sampled no earlier than the cycle after the previous `tx_start`. The cycle of a `tx_start` itself never counts as ready.
- A `req` drop mid-frame is ignored; the frame always completes. New requests are never taken until GAP ends.
- Requests that are simultaneous or pending are resolved round-robin. A channel cannot win twice in a row while another channel is requesting.

## Timing
- Reset values: `grant`=0, `rd_row`=0, `rd_col`=0, `tx_byte`=0, `tx_start`=0, `frame_done`=0, `busy`=0. Reset also sets `last`=NCH-1 (channel 0 has first priority), the checksum to 0 and the gap counter to 0.
- Reset asserted mid-frame aborts at the next edge. No further `tx_start` is issued and no `frame_done` pulse occurs.
- `req` set in IDLE at edge t: ARB at t+1, `grant` valid at t+2, first `tx_start` (HDR0) at t+3 if `tx_busy`=0.
- Data bytes: address to `tx_start` takes ≥2 cycles. Throughput is limited by `tx_busy`.
- `frame_done` rises on the cycle after `tx_busy` is first seen low following the checksum launch.
- Exactly `GAP_CYCLES` cycles elapse in GAP.

## Structure
- Package `fmap_tx_pkg`: FSM state enum, default `HDR0`/`HDR1` constants, frame-length localparam (`ROWS*COLS+4`).
- Sub-module `rr_arbiter` (NCH-wide, `last`-pointer based, one-hot output, combinational select plus registered pointer).

## Test plan
- Channel 0 alone with data[r][c]=r·6+c, UART model busy 10 cycles per byte → 40 bytes: A5 5A 00 00..23 76; `frame_done`[0] pulses once.
- Channel 1 alone with all data 8'hFF → id 01, checksum 8'hDD (9181 mod 256).
- `req`=2'b11 held, `GAP_CYCLES`=4 → frames alternate ch0, ch1, ch0; exactly 4 idle cycles between the last `tx_busy` low and the next ARB.
- `tx_busy` stretched randomly 1–200 cycles → no `tx_start` while busy or on consecutive cycles; `tx_byte` stable between starts; byte sequence unchanged.
- Reset asserted after the 12th byte → at the next edge all outputs are at reset values, no `frame_done`; next request on ch1 is granted only after ch0 (priority restarted at ch0).
- ch0 `req` dropped after the header → the frame still completes with 40 bytes and correct checksum.

Source files
------------

// File: rtl/fmap_tx_pkg.sv
// rtl/fmap_tx_pkg.sv - shared FSM type and frame constants for the feature-map transmit scheduler
package fmap_tx_pkg;

    // Frame sequencing states; encodings beyond ST_GAP are unused and recover to idle
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ARB,
        ST_SEND_HDR0,
        ST_SEND_HDR1,
        ST_SEND_ID,
        ST_RD_ADDR,
        ST_RD_CAP,
        ST_SEND_DATA,
        ST_SEND_CSUM,
        ST_GAP
    } fmap_state_t;

    localparam logic [7:0] DEF_HDR0       = 8'hA5;
    localparam logic [7:0] DEF_HDR1       = 8'h5A;

    // Two sync bytes, channel id and checksum wrap every map
    localparam int         FRAME_OVERHEAD = 4;
    localparam int         DEF_FRAME_LEN  = 6 * 6 + FRAME_OVERHEAD;

    function automatic int frame_len(input int rows, input int cols);
        return rows * cols + FRAME_OVERHEAD;
    endfunction

endpackage

// File: rtl/fmap_tx_scheduler_rr_arbiter.sv
// rtl/fmap_tx_scheduler_rr_arbiter.sv - round-robin channel picker with a registered last-grant pointer
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic          update,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    logic [IW-1:0] last;
    logic [IW-1:0] cand;

    // Remember the most recent winner so the search starts just past it; reset favours channel 0
    always_ff @(posedge clk) begin
        if (reset) begin
            last <= IW'(N - 1);
        end else if (update && any) begin
            last <= gnt_idx;
        end
    end

    // Scan last+1 .. last+N (mod N) and take the first requester found
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        cand    = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(last) + k) % N);
            if (!any && req[cand]) begin
                any     = 1'b1;
                gnt_idx = cand;
            end
        end
        if (any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/fmap_tx_scheduler.sv
// rtl/fmap_tx_scheduler.sv - shares one UART byte transmitter between feature-map sources, one framed map at a time
module fmap_tx_scheduler
    import fmap_tx_pkg::*;
#(
    parameter int         ROWS       = 6,
    parameter int         COLS       = 6,
    parameter int         NCH        = 2,
    parameter int         GAP_CYCLES = 50000,
    parameter logic [7:0] HDR0       = DEF_HDR0,
    parameter logic [7:0] HDR1       = DEF_HDR1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NCH-1:0]            req,
    output logic [NCH-1:0]            grant,
    output logic [$clog2(ROWS)-1:0]   rd_row,
    output logic [$clog2(COLS)-1:0]   rd_col,
    input  logic [NCH*8-1:0]          rd_data,
    output logic [7:0]                tx_byte,
    output logic                      tx_start,
    input  logic                      tx_busy,
    output logic [NCH-1:0]            frame_done,
    output logic                      busy
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int IW = $clog2(NCH);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    fmap_state_t   state;
    fmap_state_t   state_nx;

    logic [IW-1:0] owner;
    logic [7:0]    csum;
    logic [7:0]    data_q;
    logic          csum_sent;
    logic [GW-1:0] gap_cnt;

    logic [NCH-1:0] arb_gnt;
    logic [IW-1:0]  arb_idx;
    logic           arb_any;

    logic          tx_ready;
    logic          last_elem;
    logic          gap_done;
    logic [7:0]    id_byte;
    logic          launch;
    logic [7:0]    launch_byte;
    logic          finish;

    rr_arbiter #(
        .N  (NCH),
        .IW (IW)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .update  (state == ST_ARB),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    // The cycle carrying tx_start never counts as ready: the UART only raises busy one cycle later
    assign tx_ready  = !tx_busy && !tx_start;
    assign last_elem = (rd_row == RW'(ROWS - 1)) && (rd_col == CW'(COLS - 1));
    assign gap_done  = (gap_cnt == GW'(GAP_CYCLES - 1));
    assign id_byte   = 8'(owner);
    assign busy      = (state != ST_IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Frame sequencing: header, id, read/capture/send per byte, checksum, then the inter-frame gap
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:      if (|req) state_nx = ST_ARB;
            ST_ARB:       state_nx = arb_any ? ST_SEND_HDR0 : ST_IDLE;
            ST_SEND_HDR0: if (tx_ready) state_nx = ST_SEND_HDR1;
            ST_SEND_HDR1: if (tx_ready) state_nx = ST_SEND_ID;
            ST_SEND_ID:   if (tx_ready) state_nx = ST_RD_ADDR;
            ST_RD_ADDR:   state_nx = ST_RD_CAP;
            ST_RD_CAP:    state_nx = ST_SEND_DATA;
            ST_SEND_DATA: if (tx_ready) state_nx = last_elem ? ST_SEND_CSUM : ST_RD_ADDR;
            ST_SEND_CSUM: if (csum_sent && tx_ready) state_nx = ST_GAP;
            ST_GAP:       if (gap_done) state_nx = (|req) ? ST_ARB : ST_IDLE;
            default:      state_nx = ST_IDLE;
        endcase
    end

    // Per-state launch decision and byte selection; the checksum state also detects end of frame
    always_comb begin
        launch      = 1'b0;
        launch_byte = 8'h00;
        finish      = 1'b0;
        case (state)
            ST_SEND_HDR0: begin
                launch      = tx_ready;
                launch_byte = HDR0;
            end
            ST_SEND_HDR1: begin
                launch      = tx_ready;
                launch_byte = HDR1;
            end
            ST_SEND_ID: begin
                launch      = tx_ready;
                launch_byte = id_byte;
            end
            ST_SEND_DATA: begin
                launch      = tx_ready;
                launch_byte = data_q;
            end
            ST_SEND_CSUM: begin
                launch      = tx_ready && !csum_sent;
                launch_byte = csum;
                finish      = tx_ready && csum_sent;
            end
            default: ;
        endcase
    end

    // Datapath: grant/owner capture, address walk, checksum, tx byte hold, done pulse and gap count
    always_ff @(posedge clk) begin
        if (reset) begin
            grant      <= '0;
            owner      <= '0;
            rd_row     <= '0;
            rd_col     <= '0;
            tx_byte    <= 8'h00;
            tx_start   <= 1'b0;
            frame_done <= '0;
            csum       <= 8'h00;
            data_q     <= 8'h00;
            csum_sent  <= 1'b0;
            gap_cnt    <= '0;
        end else begin
            tx_start   <= launch;
            frame_done <= '0;
            if (launch) begin
                tx_byte <= launch_byte;
            end
            case (state)
                ST_ARB: begin
                    if (arb_any) begin
                        grant     <= arb_gnt;
                        owner     <= arb_idx;
                        csum      <= 8'h00;
                        rd_row    <= '0;
                        rd_col    <= '0;
                        csum_sent <= 1'b0;
                    end
                end
                ST_SEND_ID: begin
                    if (launch) begin
                        csum <= csum + id_byte;
                    end
                end
                ST_RD_CAP: begin
                    data_q <= rd_data[{owner, 3'b000} +: 8];
                end
                ST_SEND_DATA: begin
                    if (launch) begin
                        csum <= csum + data_q;
                        if (last_elem) begin
                            rd_row <= '0;
                            rd_col <= '0;
                        end else if (rd_col == CW'(COLS - 1)) begin
                            rd_col <= '0;
                            rd_row <= rd_row + 1'b1;
                        end else begin
                            rd_col <= rd_col + 1'b1;
                        end
                    end
                end
                ST_SEND_CSUM: begin
                    if (launch) begin
                        csum_sent <= 1'b1;
                    end else if (finish) begin
                        frame_done <= grant;
                        grant      <= '0;
                        csum_sent  <= 1'b0;
                    end
                end
                ST_GAP: begin
                    gap_cnt <= gap_done ? '0 : gap_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
